// File: rtl/pc_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pc_sequencer : fetch PC register with BOOT/RUN/HALT/TRAP sequencing.
// Optional macro PC_SEQUENCER_TRAP_EN enables the misaligned-target trap.
// Revision: 1.0
// ----------------------------------------------------------------------------
module pc_sequencer #(
  parameter int                  PC_WIDTH = 10,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [PC_WIDTH-1:0] pc_plus4,
  input  logic [PC_WIDTH-1:0] branch_target,
  input  logic [PC_WIDTH-1:0] jalr_target,
  input  logic [1:0]          pc_sel,
  input  logic                halt_req,
  output logic [PC_WIDTH-1:0] pc,
  output logic                pc_valid,
  output logic                halted,
  output logic [15:0]         retired,
  output logic                trap
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2,
    S_TRAP = 2'd3
  } state_t;

  localparam logic [PC_WIDTH-1:0] JALR_MASK  = ~{{(PC_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = {{(PC_WIDTH-2){1'b1}}, 2'b00};

  state_t              state_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] pc_d;
  logic [PC_WIDTH-1:0] tgt;
  logic [15:0]         retired_q;
  logic                pc_valid_q;
  logic                halted_q;
  logic                trap_q;
  logic                nonseq;
  logic                misaligned;

  // Reserved select 2'b11 falls back to the sequential path.
  always_comb begin
    nonseq = 1'b1;
    tgt    = branch_target;
    case (pc_sel)
      2'b01:   tgt = branch_target;
      2'b10:   tgt = jalr_target & JALR_MASK;
      default: begin
        tgt    = pc_plus4;
        nonseq = 1'b0;
      end
    endcase
  end

`ifdef PC_SEQUENCER_TRAP_EN
  assign misaligned = nonseq && (tgt[1:0] != 2'b00);
  assign pc_d       = tgt;
`else
  // With misaligned tied low, trap_q never leaves 0 and folds to a constant.
  assign misaligned = 1'b0;
  assign pc_d       = nonseq ? (tgt & ALIGN_MASK) : tgt;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_PC;
      retired_q  <= 16'h0000;
      pc_valid_q <= 1'b0;
      halted_q   <= 1'b0;
      trap_q     <= 1'b0;
    end else begin
      case (state_q)
        S_BOOT: begin
          state_q    <= S_RUN;
          pc_valid_q <= 1'b1;
        end
        S_RUN: begin
          if (en) begin
            if (halt_req) begin
              state_q    <= S_HALT;
              pc_valid_q <= 1'b0;
              halted_q   <= 1'b1;
            end else if (misaligned) begin
              state_q    <= S_TRAP;
              pc_valid_q <= 1'b0;
              trap_q     <= 1'b1;
            end else begin
              pc_q      <= pc_d;
              retired_q <= retired_q + 16'd1;
            end
          end
        end
        default: begin
          state_q <= state_q;
        end
      endcase
    end
  end

  assign pc       = pc_q;
  assign pc_valid = pc_valid_q;
  assign halted   = halted_q;
  assign retired  = retired_q;
  assign trap     = trap_q;

endmodule
`default_nettype wire
